// File: rtl/sdram_stream_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// sdram_sched_pkg
// Shared definitions for the SDRAM stream scheduler: command opcodes driven on
// cmd_op, scheduler FSM states and the default geometry constants.
// -----------------------------------------------------------------------------
package sdram_sched_pkg;

    // Command opcodes presented to the SDRAM controller on cmd_op.
    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_WR   = 2'b01,
        OP_RD   = 2'b10,
        OP_REF  = 2'b11
    } op_e;

    // Scheduler FSM states.
    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        ISSUE     = 2'b01,
        WAIT_DONE = 2'b10
    } state_e;

    // Default geometry (2 bank + 13 row + 9 col, 256-word bursts).
    localparam int ADDR_W_DEF         = 24;
    localparam int BURST_LOG2_DEF     = 8;
    localparam int FIFO_AW_DEF        = 10;
    localparam int REFRESH_PERIOD_DEF = 374;
    localparam int OVF_MARGIN_DEF     = 16;

    // Derived defaults: burst-pointer width and SDRAM depth in bursts.
    localparam int PTR_W_DEF   = ADDR_W_DEF - BURST_LOG2_DEF;
    localparam int OCC_W_DEF   = PTR_W_DEF + 1;
    localparam int DEPTH_B_DEF = 1 << PTR_W_DEF;

endpackage : sdram_sched_pkg

// File: rtl/sdram_stream_scheduler_refresh_timer.sv
// -----------------------------------------------------------------------------
// sdram_refresh_timer
// Free-running refresh interval counter (0..PERIOD-1). At the terminal count a
// refresh request becomes pending; it stays pending until the scheduler reports
// that the refresh command was accepted. Terminal counts that arrive while a
// request is already pending are absorbed.
//
// Ports:
//   clk             in   system clock
//   n_rst           in   synchronous active-low reset
//   ref_ack_i       in   refresh command accepted this cycle (clears pending)
//   ref_pending_o   out  refresh request outstanding
// -----------------------------------------------------------------------------
module sdram_refresh_timer #(
    parameter int PERIOD = 374
) (
    input  logic clk,
    input  logic n_rst,
    input  logic ref_ack_i,
    output logic ref_pending_o
);

    localparam int              CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(PERIOD - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             pend_q;
    logic             pend_d;

    // Next-state: wrap at terminal count; a fresh terminal count wins over a
    // same-cycle acknowledge so that a refresh interval is never lost.
    always_comb begin
        cnt_d  = cnt_q;
        pend_d = pend_q;
        if (cnt_q == TERM) begin
            cnt_d  = '0;
            pend_d = 1'b1;
        end else if (ref_ack_i) begin
            cnt_d  = cnt_q + CNT_W'(1);
            pend_d = 1'b0;
        end else begin
            cnt_d  = cnt_q + CNT_W'(1);
            pend_d = pend_q;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            cnt_q  <= '0;
            pend_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
        end
    end

    assign ref_pending_o = pend_q;

endmodule : sdram_refresh_timer

// File: rtl/sdram_stream_scheduler.sv
// -----------------------------------------------------------------------------
// sdram_stream_scheduler
// Arbitrates the shared SDRAM between the stream write path (FIFO_TO_SDRAM
// drain), the readback path (FIFO_FROM_SDRAM fill) and auto-refresh. The SDRAM
// is used as a circular buffer of fixed-length bursts; write/read burst
// pointers and the stored-burst occupancy are tracked here. One command is in
// flight at a time.
//
// Ports:
//   clk, n_rst          clock (CLK_48), synchronous active-low reset
//   en                  stream enable; gates new write/read grants only
//   clr                 pulse; clears pointers, occupancy and ovf
//   wr_fifo_usedw       fill level of FIFO_TO_SDRAM
//   rd_fifo_usedw       fill level of FIFO_FROM_SDRAM
//   cmd_valid/ready     command handshake with the SDRAM controller
//   cmd_op              00 none, 01 write, 10 read, 11 refresh
//   cmd_addr            burst base word address (0 for refresh)
//   burst_done          one-cycle pulse: in-flight command complete
//   sdram_rfo           at least one burst stored
//   sdram_full          every burst slot occupied
//   ovf                 sticky overflow flag
//   occupancy           number of stored bursts
// -----------------------------------------------------------------------------
module sdram_stream_scheduler
    import sdram_sched_pkg::*;
#(
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int BURST_LOG2     = BURST_LOG2_DEF,
    parameter int FIFO_AW        = FIFO_AW_DEF,
    parameter int REFRESH_PERIOD = REFRESH_PERIOD_DEF,
    parameter int OVF_MARGIN     = OVF_MARGIN_DEF
) (
    input  logic                         clk,
    input  logic                         n_rst,
    input  logic                         en,
    input  logic                         clr,
    input  logic [FIFO_AW-1:0]           wr_fifo_usedw,
    input  logic [FIFO_AW-1:0]           rd_fifo_usedw,
    output logic                         cmd_valid,
    input  logic                         cmd_ready,
    output logic [1:0]                   cmd_op,
    output logic [ADDR_W-1:0]            cmd_addr,
    input  logic                         burst_done,
    output logic                         sdram_rfo,
    output logic                         sdram_full,
    output logic                         ovf,
    output logic [ADDR_W-BURST_LOG2:0]   occupancy
);

    localparam int PTR_W = ADDR_W - BURST_LOG2;
    localparam int OCC_W = PTR_W + 1;

    localparam logic [OCC_W-1:0]   DEPTH_B     = OCC_W'(1) << PTR_W;
    // FIFO thresholds are compared one bit wider so 2^FIFO_AW is representable.
    localparam logic [FIFO_AW:0]   FIFO_DEPTH  = (FIFO_AW + 1)'(1) << FIFO_AW;
    localparam logic [FIFO_AW:0]   BURST_WORDS = (FIFO_AW + 1)'(1) << BURST_LOG2;
    localparam logic [FIFO_AW:0]   RD_LIMIT    = FIFO_DEPTH - BURST_WORDS;
    localparam logic [FIFO_AW:0]   OVF_LIMIT   = FIFO_DEPTH - (FIFO_AW + 1)'(OVF_MARGIN);

    state_e              state_q,     state_d;
    logic                cmd_valid_q, cmd_valid_d;
    op_e                 cmd_op_q,    cmd_op_d;
    logic [ADDR_W-1:0]   cmd_addr_q,  cmd_addr_d;
    op_e                 inflight_q,  inflight_d;
    logic [PTR_W-1:0]    wr_ptr_q,    wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q,    rd_ptr_d;
    logic [OCC_W-1:0]    occ_q,       occ_d;
    logic                rfo_q,       rfo_d;
    logic                full_q,      full_d;
    logic                ovf_q,       ovf_d;
    logic                last_wr_q,   last_wr_d;   // 1: last data grant was a write
    logic                clr_pend_q,  clr_pend_d;  // clr seen while an op was in flight

    logic                ref_pending_s;
    logic                ref_ack_s;
    logic                wr_elig_s;
    logic                rd_elig_s;
    logic [FIFO_AW:0]    wr_usedw_s;
    logic [FIFO_AW:0]    rd_usedw_s;

    sdram_refresh_timer #(
        .PERIOD (REFRESH_PERIOD)
    ) u_refresh_timer (
        .clk           (clk),
        .n_rst         (n_rst),
        .ref_ack_i     (ref_ack_s),
        .ref_pending_o (ref_pending_s)
    );

    assign wr_usedw_s = {1'b0, wr_fifo_usedw};
    assign rd_usedw_s = {1'b0, rd_fifo_usedw};
    assign wr_elig_s  = en && (wr_usedw_s >= BURST_WORDS) && !full_q;
    assign rd_elig_s  = en && (occ_q != '0) && (rd_usedw_s < RD_LIMIT);

    // Scheduler next-state, command generation and pointer/occupancy update.
    always_comb begin
        state_d     = state_q;
        cmd_valid_d = cmd_valid_q;
        cmd_op_d    = cmd_op_q;
        cmd_addr_d  = cmd_addr_q;
        inflight_d  = inflight_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        occ_d       = occ_q;
        last_wr_d   = last_wr_q;
        clr_pend_d  = clr_pend_q;
        ref_ack_s   = 1'b0;

        if (full_q && (wr_usedw_s >= OVF_LIMIT)) begin
            ovf_d = 1'b1;
        end else begin
            ovf_d = ovf_q;
        end

        case (state_q)
            IDLE: begin
                if (clr) begin
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                    occ_d    = '0;
                    ovf_d    = 1'b0;
                end else begin
                    occ_d    = occ_q;
                end
                // Data grants are held off in a clr cycle: their eligibility
                // was computed from the occupancy being cleared.
                if (ref_pending_s) begin
                    state_d     = ISSUE;
                    cmd_valid_d = 1'b1;
                    cmd_op_d    = OP_REF;
                    cmd_addr_d  = '0;
                    inflight_d  = OP_REF;
                end else if (!clr && wr_elig_s && (!rd_elig_s || !last_wr_q)) begin
                    state_d     = ISSUE;
                    cmd_valid_d = 1'b1;
                    cmd_op_d    = OP_WR;
                    cmd_addr_d  = {wr_ptr_q, {BURST_LOG2{1'b0}}};
                    inflight_d  = OP_WR;
                    last_wr_d   = 1'b1;
                end else if (!clr && rd_elig_s) begin
                    state_d     = ISSUE;
                    cmd_valid_d = 1'b1;
                    cmd_op_d    = OP_RD;
                    cmd_addr_d  = {rd_ptr_q, {BURST_LOG2{1'b0}}};
                    inflight_d  = OP_RD;
                    last_wr_d   = 1'b0;
                end else begin
                    state_d     = IDLE;
                end
            end

            ISSUE: begin
                if (clr) begin
                    clr_pend_d = 1'b1;
                end else begin
                    clr_pend_d = clr_pend_q;
                end
                if (cmd_ready) begin
                    state_d     = WAIT_DONE;
                    cmd_valid_d = 1'b0;
                    cmd_op_d    = OP_NONE;
                    cmd_addr_d  = '0;
                    ref_ack_s   = (inflight_q == OP_REF);
                end else begin
                    state_d     = ISSUE;
                end
            end

            WAIT_DONE: begin
                if (clr) begin
                    clr_pend_d = 1'b1;
                end else begin
                    clr_pend_d = clr_pend_q;
                end
                if (burst_done) begin
                    state_d    = IDLE;
                    inflight_d = OP_NONE;
                    if (clr_pend_q || clr) begin
                        // Latched clear: the completing burst's update is dropped.
                        wr_ptr_d   = '0;
                        rd_ptr_d   = '0;
                        occ_d      = '0;
                        ovf_d      = 1'b0;
                        clr_pend_d = 1'b0;
                    end else begin
                        case (inflight_q)
                            OP_WR: begin
                                wr_ptr_d = wr_ptr_q + PTR_W'(1);
                                occ_d    = occ_q + OCC_W'(1);
                            end
                            OP_RD: begin
                                rd_ptr_d = rd_ptr_q + PTR_W'(1);
                                occ_d    = occ_q - OCC_W'(1);
                            end
                            default: begin
                                occ_d    = occ_q;
                            end
                        endcase
                    end
                end else begin
                    state_d = WAIT_DONE;
                end
            end

            default: begin
                state_d     = IDLE;
                cmd_valid_d = 1'b0;
                cmd_op_d    = OP_NONE;
                cmd_addr_d  = '0;
                inflight_d  = OP_NONE;
            end
        endcase

        // Status flags follow the occupancy being written this cycle.
        rfo_d  = (occ_d != '0);
        full_d = (occ_d == DEPTH_B);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            cmd_valid_q <= 1'b0;
            cmd_op_q    <= OP_NONE;
            cmd_addr_q  <= '0;
            inflight_q  <= OP_NONE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            rfo_q       <= 1'b0;
            full_q      <= 1'b0;
            ovf_q       <= 1'b0;
            last_wr_q   <= 1'b0;
            clr_pend_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_op_q    <= cmd_op_d;
            cmd_addr_q  <= cmd_addr_d;
            inflight_q  <= inflight_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            rfo_q       <= rfo_d;
            full_q      <= full_d;
            ovf_q       <= ovf_d;
            last_wr_q   <= last_wr_d;
            clr_pend_q  <= clr_pend_d;
        end
    end

    assign cmd_valid  = cmd_valid_q;
    assign cmd_op     = cmd_op_q;
    assign cmd_addr   = cmd_addr_q;
    assign sdram_rfo  = rfo_q;
    assign sdram_full = full_q;
    assign ovf        = ovf_q;
    assign occupancy  = occ_q;

endmodule : sdram_stream_scheduler

// File: tb/tb_sdram_stream_scheduler.sv
// -----------------------------------------------------------------------------
// tb_sdram_stream_scheduler
// Directed bench for a reduced-geometry build (ADDR_W=10 -> 4 bursts of 256
// words) so that full/wrap conditions are reachable. Inputs change on the
// falling edge, outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_sdram_stream_scheduler;

    logic        clk;
    logic        n_rst;
    logic        en;
    logic        clr;
    logic [9:0]  wr_usedw;
    logic [9:0]  rd_usedw;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [9:0]  cmd_addr;
    logic        burst_done;
    logic        sdram_rfo;
    logic        sdram_full;
    logic        ovf;
    logic [2:0]  occupancy;

    int checks;
    int errors;

    sdram_stream_scheduler #(
        .ADDR_W         (10),
        .BURST_LOG2     (8),
        .FIFO_AW        (10),
        .REFRESH_PERIOD (374),
        .OVF_MARGIN     (16)
    ) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .en            (en),
        .clr           (clr),
        .wr_fifo_usedw (wr_usedw),
        .rd_fifo_usedw (rd_usedw),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_addr      (cmd_addr),
        .burst_done    (burst_done),
        .sdram_rfo     (sdram_rfo),
        .sdram_full    (sdram_full),
        .ovf           (ovf),
        .occupancy     (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Accept and complete a refresh that interrupts a directed scenario.
    task automatic service_ref();
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        burst_done = 1'b1;
        @(negedge clk);
        burst_done = 1'b0;
    endtask

    // Wait for the next command (servicing unexpected refreshes), compare it,
    // and optionally accept it so the DUT ends in WAIT_DONE.
    task automatic wait_cmd(input logic [1:0] exp_op, input logic [9:0] exp_addr,
                            input string name, input bit accept);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge clk);
            if (cmd_valid) begin
                if (cmd_op == 2'b11 && exp_op != 2'b11) service_ref();
                else got = 1'b1;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s: no command offered, required op %0d", name, exp_op);
            return;
        end
        if (cmd_op !== exp_op || cmd_addr !== exp_addr) begin
            errors++;
            $display("FAIL %s: op %0d addr 0x%03h, required op %0d addr 0x%03h",
                     name, cmd_op, cmd_addr, exp_op, exp_addr);
        end
        if (accept) begin
            cmd_ready = 1'b1;
            @(negedge clk);
            cmd_ready = 1'b0;
            checks++;
            if (cmd_valid !== 1'b0) begin
                errors++;
                $display("FAIL %s_accept: cmd_valid %0b, required 0", name, cmd_valid);
            end
        end
    endtask

    task automatic finish_op();
        burst_done = 1'b1;
        @(negedge clk);
        burst_done = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (cmd_valid !== 1'b0 || cmd_op !== 2'b00 || cmd_addr !== 10'h000) begin
            errors++;
            $display("FAIL reset_cmd: valid %0b op %0d addr 0x%03h, required 0 0 0",
                     cmd_valid, cmd_op, cmd_addr);
        end
        checks++;
        if (occupancy !== 3'd0 || sdram_rfo !== 1'b0 || sdram_full !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_status: occ %0d rfo %0b full %0b ovf %0b, required 0 0 0 0",
                     occupancy, sdram_rfo, sdram_full, ovf);
        end
    endtask

    task automatic test_refresh();
        n_rst = 1'b1;
        repeat (374) @(negedge clk);
        checks++;
        if (cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL ref_early: cmd_valid %0b at cycle 374, required 0", cmd_valid);
        end
        @(negedge clk);
        checks++;
        if (cmd_valid !== 1'b1 || cmd_op !== 2'b11 || cmd_addr !== 10'h000) begin
            errors++;
            $display("FAIL ref_offer: valid %0b op %0d addr 0x%03h, required 1 3 0x000",
                     cmd_valid, cmd_op, cmd_addr);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (cmd_valid !== 1'b1 || cmd_op !== 2'b11) begin
                errors++;
                $display("FAIL ref_hold%0d: valid %0b op %0d, required 1 3", i, cmd_valid, cmd_op);
            end
        end
        service_ref();
        checks++;
        if (cmd_valid !== 1'b0 || occupancy !== 3'd0) begin
            errors++;
            $display("FAIL ref_done: valid %0b occ %0d, required 0 0", cmd_valid, occupancy);
        end
    endtask

    task automatic test_done_ignored();
        burst_done = 1'b1;
        @(negedge clk);
        burst_done = 1'b0;
        @(negedge clk);
        checks++;
        if (occupancy !== 3'd0 || cmd_valid !== 1'b0) begin
            errors++;
            $display("FAIL done_idle: occ %0d valid %0b, required 0 0", occupancy, cmd_valid);
        end
    endtask

    task automatic test_write();
        rd_usedw = 10'd800;
        wr_usedw = 10'd256;
        en = 1'b1;
        wait_cmd(2'b01, 10'h000, "wr0", 1'b1);
        finish_op();
        checks++;
        if (occupancy !== 3'd1 || sdram_rfo !== 1'b1 || sdram_full !== 1'b0) begin
            errors++;
            $display("FAIL wr0_done: occ %0d rfo %0b full %0b, required 1 1 0",
                     occupancy, sdram_rfo, sdram_full);
        end
        wait_cmd(2'b01, 10'h100, "wr1", 1'b1);
        en = 1'b0;
        finish_op();
        checks++;
        if (occupancy !== 3'd2) begin
            errors++;
            $display("FAIL wr1_done: occ %0d, required 2", occupancy);
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] ops   [4] = '{2'b10, 2'b01, 2'b10, 2'b01};
        logic [9:0] addrs [4] = '{10'h000, 10'h200, 10'h100, 10'h300};
        logic [2:0] occs  [4] = '{3'd1, 3'd2, 3'd1, 3'd2};
        rd_usedw = 10'd0;
        wr_usedw = 10'd256;
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_cmd(ops[i], addrs[i], $sformatf("rr%0d", i), 1'b1);
            if (i == 3) en = 1'b0;
            finish_op();
            checks++;
            if (occupancy !== occs[i]) begin
                errors++;
                $display("FAIL rr%0d_occ: occ %0d, required %0d", i, occupancy, occs[i]);
            end
        end
    endtask

    task automatic test_refresh_priority();
        en = 1'b1;
        wait_cmd(2'b10, 10'h200, "pri_rd", 1'b1);
        repeat (400) @(negedge clk);
        finish_op();
        wait_cmd(2'b11, 10'h000, "pri_ref", 1'b1);
        finish_op();
        wait_cmd(2'b01, 10'h000, "pri_wr_wrap", 1'b1);
        en = 1'b0;
        finish_op();
        checks++;
        if (occupancy !== 3'd2) begin
            errors++;
            $display("FAIL pri_occ: occ %0d, required 2", occupancy);
        end
    endtask

    task automatic test_full_ovf();
        bit saw_wr;
        rd_usedw = 10'd800;
        wr_usedw = 10'd256;
        en = 1'b1;
        wait_cmd(2'b01, 10'h100, "fill0", 1'b1);
        finish_op();
        wait_cmd(2'b01, 10'h200, "fill1", 1'b1);
        finish_op();
        checks++;
        if (occupancy !== 3'd4 || sdram_full !== 1'b1 || sdram_rfo !== 1'b1 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL full: occ %0d full %0b rfo %0b ovf %0b, required 4 1 1 0",
                     occupancy, sdram_full, sdram_rfo, ovf);
        end
        saw_wr = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cmd_valid && cmd_op == 2'b11) service_ref();
            else if (cmd_valid) saw_wr = 1'b1;
        end
        checks++;
        if (saw_wr) begin
            errors++;
            $display("FAIL full_block: command issued while full, required none");
        end
        wr_usedw = 10'd1007;
        repeat (2) @(negedge clk);
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_below: ovf %0b at usedw 1007, required 0", ovf);
        end
        wr_usedw = 10'd1010;
        repeat (2) @(negedge clk);
        checks++;
        if (ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set: ovf %0b at usedw 1010, required 1", ovf);
        end
        wr_usedw = 10'd0;
        repeat (5) @(negedge clk);
        checks++;
        if (ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_sticky: ovf %0b, required 1", ovf);
        end
        rd_usedw = 10'd0;
        wait_cmd(2'b10, 10'h300, "rd_ptr3", 1'b1);
        finish_op();
        checks++;
        if (occupancy !== 3'd3 || sdram_full !== 1'b0) begin
            errors++;
            $display("FAIL rd_ptr3_done: occ %0d full %0b, required 3 0", occupancy, sdram_full);
        end
        wait_cmd(2'b10, 10'h000, "rd_wrap", 1'b1);
        en = 1'b0;
        finish_op();
        checks++;
        if (occupancy !== 3'd2) begin
            errors++;
            $display("FAIL rd_wrap_done: occ %0d, required 2", occupancy);
        end
    endtask

    task automatic test_rd_threshold();
        bit saw_rd;
        wr_usedw = 10'd0;
        rd_usedw = 10'd768;
        en = 1'b1;
        saw_rd = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (cmd_valid && cmd_op == 2'b11) service_ref();
            else if (cmd_valid) saw_rd = 1'b1;
        end
        checks++;
        if (saw_rd) begin
            errors++;
            $display("FAIL rd_block: read issued at rd_usedw 768, required none");
        end
        rd_usedw = 10'd767;
        wait_cmd(2'b10, 10'h100, "rd_767", 1'b1);
        en = 1'b0;
        finish_op();
        checks++;
        if (occupancy !== 3'd1) begin
            errors++;
            $display("FAIL rd_767_done: occ %0d, required 1", occupancy);
        end
    endtask

    task automatic test_clr_and_reset();
        wr_usedw = 10'd256;
        rd_usedw = 10'd800;
        en = 1'b1;
        wait_cmd(2'b01, 10'h300, "clr_wr", 1'b1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        en = 1'b0;
        repeat (3) @(negedge clk);
        finish_op();
        checks++;
        if (occupancy !== 3'd0 || sdram_rfo !== 1'b0 || sdram_full !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL clr_done: occ %0d rfo %0b full %0b ovf %0b, required 0 0 0 0",
                     occupancy, sdram_rfo, sdram_full, ovf);
        end
        en = 1'b1;
        wait_cmd(2'b01, 10'h000, "post_clr_wr", 1'b1);
        finish_op();
        wait_cmd(2'b01, 10'h100, "rst_issue_wr", 1'b0);
        checks++;
        if (occupancy !== 3'd1) begin
            errors++;
            $display("FAIL pre_rst_occ: occ %0d, required 1", occupancy);
        end
        n_rst = 1'b0;
        @(negedge clk);
        checks++;
        if (cmd_valid !== 1'b0 || cmd_op !== 2'b00 || cmd_addr !== 10'h000 ||
            occupancy !== 3'd0 || sdram_rfo !== 1'b0) begin
            errors++;
            $display("FAIL rst_issue: valid %0b op %0d addr 0x%03h occ %0d rfo %0b, required 0 0 0 0 0",
                     cmd_valid, cmd_op, cmd_addr, occupancy, sdram_rfo);
        end
        n_rst = 1'b1;
        wait_cmd(2'b01, 10'h000, "post_rst_wr", 1'b1);
        en = 1'b0;
        finish_op();
        checks++;
        if (occupancy !== 3'd1) begin
            errors++;
            $display("FAIL post_rst_occ: occ %0d, required 1", occupancy);
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        n_rst      = 1'b0;
        en         = 1'b0;
        clr        = 1'b0;
        wr_usedw   = 10'd0;
        rd_usedw   = 10'd0;
        cmd_ready  = 1'b0;
        burst_done = 1'b0;
        repeat (3) @(negedge clk);

        test_reset();
        test_refresh();
        test_done_ignored();
        test_write();
        test_round_robin();
        test_refresh_priority();
        test_full_ovf();
        test_rd_threshold();
        test_clr_and_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_sdram_stream_scheduler
